// File: rtl/ifft_recon_pkg.sv
// Shared types and sizes for the inverse sum/difference reconstruction block.
package ifft_recon_pkg;
    localparam int N        = 16;
    localparam int HALF     = 8;
    localparam int SAMPLE_W = 16;
    localparam int IDX_W    = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        STREAM
    } state_t;
endpackage

// File: rtl/ifft_recon_butterfly.sv
// One inverse butterfly: (s, d) -> ((s+d)/2, (s-d)/2) with a flag for inexact halving.
module recon_butterfly
    import ifft_recon_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W
) (
    input  logic signed [DATA_W-1:0] s,
    input  logic signed [DATA_W-1:0] d,
    output logic signed [DATA_W-1:0] x_lo,
    output logic signed [DATA_W-1:0] x_hi,
    output logic                     odd_flag
);

    // Arithmetic shift of the 17-bit value, keeping the low DATA_W bits.
    function automatic logic signed [DATA_W-1:0] halve(input logic signed [DATA_W:0] v);
        return v[DATA_W:1];
    endfunction

    logic signed [DATA_W:0] p;
    logic signed [DATA_W:0] m;

    assign p        = {s[DATA_W-1], s} + {d[DATA_W-1], d};
    assign m        = {s[DATA_W-1], s} - {d[DATA_W-1], d};
    assign x_lo     = halve(p);
    assign x_hi     = halve(m);
    assign odd_flag = p[0] | m[0];

endmodule

// File: rtl/ifft_recon.sv
// Captures one frame of sums/differences, reconstructs 16 samples in one cycle
// and streams them out last-index-first under a valid/ready handshake.
module ifft_recon
    import ifft_recon_pkg::*;
#(
    parameter int W = SAMPLE_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] frame_in,
    input  logic           frame_valid,
    output logic           frame_ready,
    output logic [W-1:0]   audio_out,
    output logic           audio_valid,
    input  logic           audio_ready,
    output logic           busy,
    output logic           parity_err
);

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [N*W-1:0]       frame_p0;
    logic signed [W-1:0]  x_p1 [N];
    logic signed [W-1:0]  lo [HALF];
    logic signed [W-1:0]  hi [HALF];
    logic [HALF-1:0]      odd;
    logic                 accept;

    assign accept = (state == IDLE) && frame_valid && frame_ready;

    // Stage p0 -> p1: eight parallel butterflies on the captured frame
    for (genvar j = 0; j < HALF; j++) begin : g_bfly
        recon_butterfly #(.DATA_W(W)) u_bfly (
            .s        (frame_p0[W*j +: W]),
            .d        (frame_p0[W*(j+HALF) +: W]),
            .x_lo     (lo[j]),
            .x_hi     (hi[j]),
            .odd_flag (odd[j])
        );
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            frame_p0 <= frame_in;
        end
        if (state == CALC) begin
            for (int j = 0; j < HALF; j++) begin
                x_p1[j]      <= lo[j];
                x_p1[j+HALF] <= hi[j];
            end
        end
    end

    // Stage p1 -> output: audio_out is loaded one cycle after CALC, then per accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= IDX_W'(N-1);
            frame_ready <= 1'b0;
            audio_valid <= 1'b0;
            audio_out   <= '0;
            busy        <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= CALC;
                        frame_ready <= 1'b0;
                        busy        <= 1'b1;
                    end else begin
                        frame_ready <= 1'b1;
                    end
                end
                CALC: begin
                    if (|odd) begin
                        parity_err <= 1'b1;
                    end
                    idx   <= IDX_W'(N-1);
                    state <= STREAM;
                end
                STREAM: begin
                    if (!audio_valid) begin
                        audio_valid <= 1'b1;
                        audio_out   <= x_p1[idx];
                    end else if (audio_ready) begin
                        if (idx == '0) begin
                            state       <= IDLE;
                            audio_valid <= 1'b0;
                            frame_ready <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            idx       <= idx - 1'b1;
                            audio_out <= x_p1[idx - 1'b1];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_recon.sv
// Randomised and directed checks of ifft_recon against an arithmetic reference model.
module tb_ifft_recon;
    import ifft_recon_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [255:0]   frame_in = '0;
    logic           frame_valid = 1'b0;
    logic           frame_ready;
    logic [15:0]    audio_out;
    logic           audio_valid;
    logic           audio_ready = 1'b0;
    logic           busy;
    logic           parity_err;

    int n_checks = 0;
    int n_pass = 0;
    bit exp_par = 1'b0;

    logic [15:0] cap_beats [16];
    int          cap_got;
    bit          cap_stable;
    bit          cap_fr_seen;

    ifft_recon #(.W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .busy        (busy),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d beats", cap_got);
        $fatal(1, "watchdog");
    end

    // x[k] = (s_j + d_j) / 2 for k < 8, (s_j - d_j) / 2 for k >= 8, floor, mod 2^16
    function automatic logic [15:0] ref_x(input logic [255:0] f, input int k);
        int j, s, d, r;
        j = k % 8;
        s = int'($signed(f[16*j +: 16]));
        d = int'($signed(f[16*(j+8) +: 16]));
        r = (k < 8) ? s + d : s - d;
        return 16'(r >>> 1);
    endfunction

    function automatic bit ref_odd(input logic [255:0] f);
        bit o = 1'b0;
        for (int j = 0; j < 8; j++) begin
            int s, d;
            s = int'($signed(f[16*j +: 16]));
            d = int'($signed(f[16*(j+8) +: 16]));
            if (((s + d) & 1) != 0) o = 1'b1;
        end
        return o;
    endfunction

    function automatic logic [255:0] rand_frame();
        logic [255:0] f;
        for (int i = 0; i < 16; i++) f[16*i +: 16] = 16'($urandom);
        return f;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_par = 1'b0;
    endtask

    task automatic send_frame(input logic [255:0] f);
        bit ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (frame_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_frame: frame_ready=%0b, required 1 within 60 cycles", frame_ready);
        end
        frame_in = f;
        frame_valid = 1'b1;
        @(posedge clk);
        #1 frame_valid = 1'b0;
    endtask

    // Collects up to nmax accepted beats; optionally stalls for 5 cycles once stall_at beats are in.
    task automatic capture(input int stall_pct, input int stall_at, input int nmax);
        int left = 0;
        bit done = 1'b0;
        logic [15:0] held = '0;
        cap_got = 0;
        cap_stable = 1'b1;
        cap_fr_seen = 1'b0;
        for (int c = 0; c < 600 && cap_got < nmax; c++) begin
            @(negedge clk);
            if (frame_ready) cap_fr_seen = 1'b1;
            if (left > 0) begin
                if (!audio_valid || audio_out !== held) cap_stable = 1'b0;
                left--;
                audio_ready = 1'b0;
            end else if (!done && cap_got == stall_at && audio_valid) begin
                held = audio_out;
                done = 1'b1;
                left = 4;
                audio_ready = 1'b0;
            end else begin
                audio_ready = ($urandom_range(99) >= stall_pct);
                if (audio_valid && audio_ready) begin
                    cap_beats[cap_got] = audio_out;
                    cap_got++;
                end
            end
        end
        audio_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({frame_ready, audio_valid, busy, parity_err} !== 4'b0000) $display("FAIL reset_ctrl: fr/av/busy/perr=%b, required 0000", {frame_ready, audio_valid, busy, parity_err});
        else n_pass++;
        n_checks++;
        if (audio_out !== 16'h0000) $display("FAIL reset_audio_out: got %h, required 0000", audio_out);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (frame_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release: frame_ready=%b busy=%b, required 1 0", frame_ready, busy);
        else n_pass++;
    endtask

    task automatic test_zero_frame();
        logic v [25];
        logic r [25];
        int first_v = -1, first_r = -1, nv = 0;
        bit nz = 1'b0;
        audio_ready = 1'b1;
        send_frame('0);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            v[c] = audio_valid;
            r[c] = frame_ready;
            if (audio_valid) begin
                nv++;
                if (audio_out !== 16'h0000) nz = 1'b1;
            end
        end
        for (int c = 24; c >= 0; c--) begin
            if (v[c]) first_v = c;
            if (r[c]) first_r = c;
        end
        n_checks++;
        if (first_v != 2) $display("FAIL zero_first_valid: cycle %0d after accept, required 2", first_v);
        else n_pass++;
        n_checks++;
        if (nv != 16) $display("FAIL zero_beat_count: got %0d, required 16", nv);
        else n_pass++;
        n_checks++;
        if (first_r != 18) $display("FAIL zero_ready_return: cycle %0d after accept, required 18", first_r);
        else n_pass++;
        n_checks++;
        if (nz) $display("FAIL zero_data: a nonzero beat was seen, required all 0000");
        else n_pass++;
        n_checks++;
        if (parity_err !== 1'b0) $display("FAIL zero_parity: got %b, required 0", parity_err);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [255:0] f = '0;
        logic [15:0] want;
        f[15:0] = 16'h0006;
        f[8*16 +: 16] = 16'h0002;
        send_frame(f);
        capture(0, -1, 16);
        n_checks++;
        if (cap_got != 16) $display("FAIL directed_count: got %0d beats, required 16", cap_got);
        else n_pass++;
        for (int b = 0; b < 16; b++) begin
            want = (b == 7) ? 16'h0002 : (b == 15) ? 16'h0004 : 16'h0000;
            n_checks++;
            if (cap_beats[b] !== want) $display("FAIL directed_beat%0d: got %h, required %h", b + 1, cap_beats[b], want);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] fa = rand_frame();
        logic [255:0] fb = rand_frame();
        audio_ready = 1'b1;
        send_frame(fa);
        frame_in = fb;
        frame_valid = 1'b1;
        capture(0, -1, 16);
        n_checks++;
        if (cap_fr_seen) $display("FAIL b2b_ready_during_stream: frame_ready seen 1, required 0");
        else n_pass++;
        for (int b = 0; b < 16; b++) begin
            n_checks++;
            if (cap_beats[b] !== ref_x(fa, 15 - b)) $display("FAIL b2b_a_beat%0d: got %h, required %h", b + 1, cap_beats[b], ref_x(fa, 15 - b));
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (frame_ready !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_idle: frame_ready=%b busy=%b, required 1 0", frame_ready, busy);
        else n_pass++;
        @(posedge clk);
        #1 frame_valid = 1'b0;
        capture(20, -1, 16);
        n_checks++;
        if (cap_got != 16) $display("FAIL b2b_b_count: got %0d beats, required 16", cap_got);
        else n_pass++;
        for (int b = 0; b < 16; b++) begin
            n_checks++;
            if (cap_beats[b] !== ref_x(fb, 15 - b)) $display("FAIL b2b_b_beat%0d: got %h, required %h", b + 1, cap_beats[b], ref_x(fb, 15 - b));
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_no_requeue: busy=%b, required 0", busy);
        else n_pass++;
        exp_par = exp_par | ref_odd(fa) | ref_odd(fb);
    endtask

    task automatic test_backpressure();
        logic [255:0] f = rand_frame();
        send_frame(f);
        capture(0, 5, 16);
        n_checks++;
        if (!cap_stable) $display("FAIL stall_hold: audio_out/valid changed during stall, required stable");
        else n_pass++;
        n_checks++;
        if (cap_got != 16) $display("FAIL stall_count: got %0d beats, required 16", cap_got);
        else n_pass++;
        for (int b = 0; b < 16; b++) begin
            n_checks++;
            if (cap_beats[b] !== ref_x(f, 15 - b)) $display("FAIL stall_beat%0d: got %h, required %h", b + 1, cap_beats[b], ref_x(f, 15 - b));
            else n_pass++;
        end
        exp_par = exp_par | ref_odd(f);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            logic [255:0] f = rand_frame();
            send_frame(f);
            capture(40, -1, 16);
            exp_par = exp_par | ref_odd(f);
            n_checks++;
            if (cap_got != 16) $display("FAIL rand%0d_count: got %0d beats, required 16", t, cap_got);
            else n_pass++;
            for (int b = 0; b < 16; b++) begin
                n_checks++;
                if (cap_beats[b] !== ref_x(f, 15 - b)) $display("FAIL rand%0d_beat%0d: got %h, required %h", t, b + 1, cap_beats[b], ref_x(f, 15 - b));
                else n_pass++;
            end
            n_checks++;
            if (parity_err !== exp_par) $display("FAIL rand%0d_parity: got %b, required %b", t, parity_err, exp_par);
            else n_pass++;
        end
    endtask

    task automatic test_extreme();
        logic [255:0] f = '0;
        f[1*16 +: 16] = 16'h7FFF;
        f[9*16 +: 16] = 16'h8000;
        f[2*16 +: 16] = 16'h8000;
        f[10*16 +: 16] = 16'h8000;
        f[3*16 +: 16] = 16'h7FFF;
        f[11*16 +: 16] = 16'h7FFF;
        send_frame(f);
        capture(10, -1, 16);
        exp_par = exp_par | ref_odd(f);
        n_checks++;
        if (cap_beats[14] !== 16'hFFFF) $display("FAIL extreme_x1: got %h, required FFFF", cap_beats[14]);
        else n_pass++;
        n_checks++;
        if (cap_beats[6] !== 16'h7FFF) $display("FAIL extreme_x9: got %h, required 7FFF", cap_beats[6]);
        else n_pass++;
        for (int b = 0; b < 16; b++) begin
            n_checks++;
            if (cap_beats[b] !== ref_x(f, 15 - b)) $display("FAIL extreme_beat%0d: got %h, required %h", b + 1, cap_beats[b], ref_x(f, 15 - b));
            else n_pass++;
        end
    endtask

    task automatic test_parity();
        logic [255:0] clean = '0;
        logic [255:0] odd = '0;
        clean[0 +: 16] = 16'h0002;
        clean[8*16 +: 16] = 16'h0004;
        odd[3*16 +: 16] = 16'h0003;
        do_reset();
        n_checks++;
        if (parity_err !== 1'b0) $display("FAIL parity_after_reset: got %b, required 0", parity_err);
        else n_pass++;
        send_frame(clean);
        capture(0, -1, 16);
        n_checks++;
        if (parity_err !== 1'b0) $display("FAIL parity_clean: got %b, required 0", parity_err);
        else n_pass++;
        send_frame(odd);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (parity_err !== 1'b1) $display("FAIL parity_set_after_calc: got %b, required 1", parity_err);
        else n_pass++;
        capture(0, -1, 16);
        n_checks++;
        if (cap_beats[12] !== 16'h0001) $display("FAIL parity_x3: got %h, required 0001", cap_beats[12]);
        else n_pass++;
        send_frame(clean);
        capture(0, -1, 16);
        n_checks++;
        if (parity_err !== 1'b1) $display("FAIL parity_sticky: got %b, required 1", parity_err);
        else n_pass++;
        do_reset();
        n_checks++;
        if (parity_err !== 1'b0) $display("FAIL parity_cleared: got %b, required 0", parity_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [255:0] f = rand_frame();
        int nv = 0;
        audio_ready = 1'b1;
        send_frame(f);
        capture(0, -1, 7);
        n_checks++;
        if (cap_beats[6] !== ref_x(f, 9)) $display("FAIL rstmid_beat7: got %h, required %h", cap_beats[6], ref_x(f, 9));
        else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({audio_valid, busy, frame_ready} !== 3'b000) $display("FAIL rstmid_in_reset: av/busy/fr=%b, required 000", {audio_valid, busy, frame_ready});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (frame_ready !== 1'b1) $display("FAIL rstmid_ready: got %b, required 1", frame_ready);
        else n_pass++;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (audio_valid) nv++;
        end
        n_checks++;
        if (nv != 0) $display("FAIL rstmid_no_beats: got %0d valid cycles, required 0", nv);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_extreme();
        test_parity();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifft_recon.md
IFFT_RECON -- requirements
Module: ifft_recon

Interface
REQ-001 Parameter W SHALL default to 16; it is the sample width, and the implementation SHALL support only 16.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 frame_in  input  256  sixteen 16-bit signed words; word k occupies bits [16k+15:16k]; k=0..7 are sums s_k, k=8..15 are differences d_(k-8).
REQ-005 frame_valid  input  1  frame_in holds a complete frame.
REQ-006 frame_ready  output  1  block can accept a frame.
REQ-007 audio_out  output  16  reconstructed signed sample.
REQ-008 audio_valid  output  1  audio_out holds a valid sample.
REQ-009 audio_ready  input  1  the downstream block accepts audio_out.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 parity_err  output  1  sticky flag: a non-exact reconstruction was detected.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and STREAM.
REQ-013 In IDLE, frame_ready SHALL be 1; a transfer occurs when frame_valid and frame_ready are both high, and frame_in SHALL then be registered and the FSM SHALL move to CALC.
REQ-014 In CALC (exactly 1 cycle), for each j=0..7 the block SHALL form p=s_j+d_j and m=s_j-d_j as 17-bit signed values.
REQ-015 In the same CALC cycle it SHALL store x[j]=p>>>1 and x[j+8]=m>>>1 (arithmetic shift, low 16 bits kept), set the index to 15 and move to STREAM.
REQ-016 If the LSB of any p or m is 1 during CALC, parity_err SHALL be set to 1 and remain at 1 until reset.
REQ-017 In STREAM, audio_valid SHALL be 1 and audio_out SHALL equal x[index]; samples SHALL be emitted in the order x[15], x[14], …, x[0], oldest first.
REQ-018 While audio_valid=1 and audio_ready=0, audio_out SHALL hold stable.
REQ-019 On each beat where audio_valid=1 and audio_ready=1, the index SHALL decrement; when the beat with index 0 is accepted, the FSM SHALL return to IDLE, audio_valid SHALL drop and frame_ready SHALL rise on the next cycle.
REQ-020 Latency: with the frame accepted at edge T, the first audio_valid SHALL be seen after edge T+2; with audio_ready held high, a frame SHALL take 18 cycles from acceptance to frame_ready returning high.
REQ-021 frame_ready SHALL be 0 outside IDLE; a frame_valid arriving then SHALL be ignored and not queued.
REQ-022 audio_ready toggling outside STREAM SHALL have no effect.
REQ-023 Arithmetic SHALL use 17-bit intermediates so that no sum or difference overflows; extreme inputs such as s=0x7FFF, d=0x8000 SHALL give a result that is exact modulo 2^16 after the shift.

Reset
REQ-024 When rst_n=0 at a rising edge: FSM to IDLE, index 15, frame_ready 0, audio_valid 0, audio_out 0x0000, busy 0, parity_err 0.
REQ-025 frame_ready SHALL be 1 from the first edge with rst_n=1.
REQ-026 A reset during CALC or STREAM SHALL drop the frame; no further samples of that frame SHALL be emitted.
REQ-027 Frame and sample storage need no reset.

Structure
REQ-028 Package ifft_recon_pkg SHALL hold the state enum (IDLE, CALC, STREAM), the frame size N=16, HALF=8 and the sample width 16.
REQ-029 A combinational sub-module recon_butterfly SHALL map one (s, d) pair to (x_lo, x_hi, odd_flag); it SHALL be instantiated 8 times.
REQ-030 The top level SHALL contain the FSM, the index counter, the capture and sample registers, and the handshake logic.

Verification
REQ-031 All-zero frame, audio_ready=1 -> 16 beats of 0x0000; first valid at T+2; frame_ready back high at T+18; parity_err=0.
REQ-032 s_0=0x0006, d_0=0x0002, all other words 0 -> x[0]=0x0004, x[8]=0x0002; emitted as beat 16 and beat 8 respectively.
REQ-033 audio_ready held low for 5 cycles mid-stream -> audio_out and the index hold unchanged; the sequence resumes with no lost or duplicated beat.
REQ-034 s_3=0x0003, d_3=0x0000 -> parity_err=1 after CALC; the flag stays 1 across the next clean frame; reset clears it.
REQ-035 frame_valid held high during STREAM with a second frame -> frame ignored until IDLE; then accepted, and its own 16 beats follow.
REQ-036 rst_n=0 for 1 cycle at beat 7 -> audio_valid=0 next cycle, no remaining beats emitted, frame_ready=1 after reset is released.
